// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch-to-decode instruction queue.
//   FQ_XLEN    : PC width carried in a queue entry
//   NOP_INSTR  : addi x0,x0,0, driven to decode whenever no entry is valid
//   t_fq_entry : one queued fetch result {pc, instr, fault}
//   fq_ptr_w   : pointer width for a queue of a given depth (one wrap bit extra)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FQ_XLEN = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic               fault;
    } t_fq_entry;

    // The extra MSB distinguishes a full queue from an empty one when the
    // index bits of the two pointers coincide.
    function automatic int fq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundle of the fetch-side write channel, decode-side read channel, the
// redirect flush and the occupancy count.
//   master : fetch/decode side (drives wr_*, rd_ready_i, flush_i)
//   slave  : the queue itself
// Signal names keep the _i/_o direction as seen from the queue.
// -----------------------------------------------------------------------------
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN  = FQ_XLEN,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush_i;
    logic            wr_valid_i;
    logic            wr_ready_o;
    logic [31:0]     wr_instr_i;
    logic [XLEN-1:0] wr_pc_i;
    logic            wr_fault_i;
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [31:0]     rd_instr_o;
    logic [XLEN-1:0] rd_pc_o;
    logic            rd_fault_o;
    logic [CW-1:0]   count_o;

    modport master (
        output flush_i, wr_valid_i, wr_instr_i, wr_pc_i, wr_fault_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, rd_instr_o, rd_pc_o, rd_fault_o, count_o
    );

    modport slave (
        input  flush_i, wr_valid_i, wr_instr_i, wr_pc_i, wr_fault_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, rd_instr_o, rd_pc_o, rd_fault_o, count_o
    );

endinterface

// File: rtl/fq_storage.sv
// -----------------------------------------------------------------------------
// fq_storage
// DEPTH-entry register array for the fetch queue.
//   i_clk   : clock
//   i_we    : write enable (one synchronous write port)
//   i_waddr : write index
//   i_wdata : entry to store
//   i_raddr : read index (asynchronous read port)
//   o_rdata : entry at i_raddr, combinational
// Contents are deliberately not reset; the queue pointers decide validity.
// -----------------------------------------------------------------------------
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  t_fq_entry                i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output t_fq_entry                o_rdata
);

    t_fq_entry r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read so the head entry is on rd_* the cycle after it is
    // written, without an extra pipeline stage.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction buffer between fetch and decode. Holds {pc, instr, fault}
// entries in FIFO order, decode pops one per cycle unless stalled, and a
// redirect (flush_i) discards everything.
//   clk_i  : clock, rising edge
//   arst_i : asynchronous active-high reset
//   bus    : fetch_queue_if.slave
//              flush_i                          redirect, drop all entries
//              wr_valid_i/wr_ready_o            fetch handshake
//              wr_instr_i/wr_pc_i/wr_fault_i    fetched entry
//              rd_valid_o/rd_ready_i            decode handshake
//              rd_instr_o/rd_pc_o/rd_fault_o    head entry (NOP/0/0 when invalid)
//              count_o                          occupancy 0..DEPTH
// Build option:
//   FETCH_QUEUE_BYPASS_EN : when the queue is empty, forward wr_* straight to
//                           rd_*; an entry consumed that same cycle is never
//                           stored. Undefined: minimum latency is one cycle
//                           and there is no combinational wr->rd path.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FQ_XLEN
)
(
    input  logic   clk_i,
    input  logic   arst_i,
    fetch_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fq_ptr_w(DEPTH);

    // Entries carry a fixed-width PC from the package; reject configurations
    // that would silently truncate or break the pointer arithmetic.
    generate
        if (XLEN != FQ_XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
            $error("fetch_queue: XLEN must equal FQ_XLEN and DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic      w_empty;
    logic      w_full;
    logic      w_push;
    logic      w_pop;
    logic      w_rd_valid;
    t_fq_entry w_wr_entry;
    t_fq_entry w_mem_head;
    t_fq_entry w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Readiness is a function of stored state only, so fetch never sees a
    // combinational dependency on decode's stall.
    assign bus.wr_ready_o = !w_full;

    assign w_wr_entry = '{pc: bus.wr_pc_i, instr: bus.wr_instr_i, fault: bus.wr_fault_i};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;

    // Empty queue: the fetched entry is presented to decode in the same cycle.
    // If decode takes it, it is consumed here and never written to storage.
    assign w_bypass   = w_empty && !bus.flush_i && bus.wr_valid_i;
    assign w_rd_valid = !bus.flush_i && (!w_empty || bus.wr_valid_i);
    assign w_head     = w_empty ? w_wr_entry : w_mem_head;
    assign w_push     = bus.wr_valid_i && !w_full && !bus.flush_i &&
                        !(w_bypass && bus.rd_ready_i);
    assign w_pop      = !w_empty && !bus.flush_i && bus.rd_ready_i;
`else
    assign w_rd_valid = !w_empty && !bus.flush_i;
    assign w_head     = w_mem_head;
    assign w_push     = bus.wr_valid_i && !w_full && !bus.flush_i;
    assign w_pop      = w_rd_valid && bus.rd_ready_i;
`endif

    // Pointers wrap modulo 2*DEPTH through natural PW-bit overflow.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush_i) begin
            // Any push or pop offered alongside the redirect is dropped.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .i_clk   (clk_i),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_head)
    );

    // Decode must never see a stale word: invalid head reads as a NOP.
    assign bus.rd_valid_o = w_rd_valid;
    assign bus.rd_instr_o = w_rd_valid ? w_head.instr : NOP_INSTR;
    assign bus.rd_pc_o    = w_rd_valid ? w_head.pc    : '0;
    assign bus.rd_fault_o = w_rd_valid && w_head.fault;

    assign bus.count_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: entries expected at the head, in order.
    t_fq_entry sb[$];
    int        m_count = 0;

    task automatic drive(input bit wv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input bit flt, input bit rr, input bit fl);
        bus.wr_valid_i = wv;
        bus.wr_instr_i = ins;
        bus.wr_pc_i    = pc;
        bus.wr_fault_i = flt;
        bus.rd_ready_i = rr;
        bus.flush_i    = fl;
    endtask

    function automatic t_fq_entry drv_entry();
        return '{pc: bus.wr_pc_i, instr: bus.wr_instr_i, fault: bus.wr_fault_i};
    endfunction

    function automatic bit model_valid();
`ifdef FETCH_QUEUE_BYPASS_EN
        return !bus.flush_i && (m_count > 0 || bus.wr_valid_i);
`else
        return !bus.flush_i && (m_count > 0);
`endif
    endfunction

    function automatic t_fq_entry model_head();
        if (m_count > 0) return sb[0];
        return drv_entry();
    endfunction

    // Updates the model from the currently driven inputs, then advances one edge.
    task automatic clock_edge();
        bit push, pop, byp;
        push = bus.wr_valid_i && (m_count < DEPTH) && !bus.flush_i;
        pop  = bus.rd_ready_i && (m_count > 0) && !bus.flush_i;
        byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp  = push && (m_count == 0) && bus.rd_ready_i;
`endif
        if (bus.flush_i) begin
            sb.delete();
        end else if (!byp) begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(drv_entry());
        end
        m_count = sb.size();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 32'h0, '0, 0, 0, 0);
        arst_i = 1'b1;
        #2;
        n_total++;
        if (bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1 || bus.count_o !== CW'(0))
            $display("FAIL reset_ctrl got valid=%b ready=%b count=%0d want valid=0 ready=1 count=0",
                     bus.rd_valid_o, bus.wr_ready_o, bus.count_o);
        else n_pass++;
        n_total++;
        if (bus.rd_instr_o !== 32'h13 || bus.rd_pc_o !== 64'h0 || bus.rd_fault_o !== 1'b0)
            $display("FAIL reset_nop got instr=%h pc=%h fault=%b want instr=00000013 pc=0 fault=0",
                     bus.rd_instr_o, bus.rd_pc_o, bus.rd_fault_o);
        else n_pass++;
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        sb.delete();
        m_count = 0;
        $display("reset: done");
    endtask

    task automatic test_basic();
        drive(1, 32'h00A00093, 64'h1000, 0, 0, 0);
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        n_total++;
        if (bus.rd_valid_o !== 1'b0)
            $display("FAIL basic_no_bypass got valid=%b want 0", bus.rd_valid_o);
        else n_pass++;
`endif
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_instr_o !== 32'h00A00093 ||
            bus.rd_pc_o !== 64'h1000 || bus.count_o !== CW'(1))
            $display("FAIL basic_head got valid=%b instr=%h pc=%h count=%0d want 1 00a00093 1000 1",
                     bus.rd_valid_o, bus.rd_instr_o, bus.rd_pc_o, bus.count_o);
        else n_pass++;
        drive(0, 32'h0, '0, 0, 1, 0);
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b0 || bus.count_o !== CW'(0))
            $display("FAIL basic_drain got valid=%b count=%0d want 0 0", bus.rd_valid_o, bus.count_o);
        else n_pass++;
        $display("basic: push 0x00A00093@0x1000, pop");
    endtask

    task automatic test_full();
        t_fq_entry e;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h00100093 + 32'(i), 64'h3000 + 64'(4 * i), 0, 0, 0);
            clock_edge();
        end
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.count_o !== CW'(DEPTH) || bus.wr_ready_o !== 1'b0)
            $display("FAIL full_state got count=%0d ready=%b want %0d 0", bus.count_o, bus.wr_ready_o, DEPTH);
        else n_pass++;
        drive(1, 32'hDEADBEEF, 64'h9999, 0, 0, 0);
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.count_o !== CW'(DEPTH))
            $display("FAIL full_5th_push got count=%0d want %0d", bus.count_o, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 32'h0, '0, 0, 1, 0);
            #1;
            e = model_head();
            n_total++;
            if (bus.rd_valid_o !== 1'b1 || bus.rd_pc_o !== e.pc || bus.rd_instr_o !== e.instr)
                $display("FAIL full_pop%0d got valid=%b pc=%h instr=%h want 1 %h %h",
                         i, bus.rd_valid_o, bus.rd_pc_o, bus.rd_instr_o, e.pc, e.instr);
            else n_pass++;
            clock_edge();
        end
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b0 || bus.rd_instr_o !== 32'h13 || bus.count_o !== CW'(0))
            $display("FAIL full_empty got valid=%b instr=%h count=%0d want 0 00000013 0",
                     bus.rd_valid_o, bus.rd_instr_o, bus.count_o);
        else n_pass++;
        $display("full: 4 pushed, 5th refused, 4 popped in order");
    endtask

    task automatic test_back_to_back();
        t_fq_entry e;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h00200093 + 32'(i), 64'h7000 + 64'(4 * i), 0, 0, 0);
            clock_edge();
        end
        drive(1, 32'h00300093, 64'h7FF0, 0, 1, 0);
        #1;
        n_total++;
        if (bus.wr_ready_o !== 1'b0 || bus.rd_pc_o !== 64'h7000)
            $display("FAIL b2b_full got ready=%b pc=%h want 0 7000", bus.wr_ready_o, bus.rd_pc_o);
        else n_pass++;
        clock_edge();
        n_total++;
        if (bus.count_o !== CW'(3))
            $display("FAIL b2b_full_count got %0d want 3", bus.count_o);
        else n_pass++;
        drive(0, 32'h0, '0, 0, 1, 0);
        clock_edge();
        drive(1, 32'h00400093, 64'h7100, 0, 1, 0);
        #1;
        n_total++;
        if (bus.rd_pc_o !== 64'h7008 || bus.count_o !== CW'(2))
            $display("FAIL b2b_mid got pc=%h count=%0d want 7008 2", bus.rd_pc_o, bus.count_o);
        else n_pass++;
        clock_edge();
        n_total++;
        if (bus.count_o !== CW'(2))
            $display("FAIL b2b_count2 got %0d want 2", bus.count_o);
        else n_pass++;
        for (int i = 0; i < 8 && m_count > 0; i++) begin
            drive(0, 32'h0, '0, 0, 1, 0);
            #1;
            e = model_head();
            n_total++;
            if (bus.rd_valid_o !== 1'b1 || bus.rd_pc_o !== e.pc)
                $display("FAIL b2b_drain%0d got valid=%b pc=%h want 1 %h", i, bus.rd_valid_o, bus.rd_pc_o, e.pc);
            else n_pass++;
            clock_edge();
        end
        $display("back_to_back: full push+pop, count-2 push+pop");
    endtask

    task automatic test_wrap();
        int n_in  = 0;
        int n_out = 0;
        for (int cyc = 0; cyc < 60 && n_out < 20; cyc++) begin
            drive(n_in < 20, 32'h00500093 + 32'(n_in), 64'h4000 + 64'(4 * n_in), 0, 1, 0);
            #1;
            n_total++;
            if (model_valid()) begin
                if (bus.rd_valid_o !== 1'b1 || bus.rd_pc_o !== 64'h4000 + 64'(4 * n_out))
                    $display("FAIL wrap_out%0d got valid=%b pc=%h want 1 %h",
                             n_out, bus.rd_valid_o, bus.rd_pc_o, 64'h4000 + 64'(4 * n_out));
                else n_pass++;
                n_out++;
            end else begin
                if (bus.rd_valid_o !== 1'b0)
                    $display("FAIL wrap_idle got valid=%b want 0", bus.rd_valid_o);
                else n_pass++;
            end
            if (n_in < 20 && m_count < DEPTH) n_in++;
            clock_edge();
        end
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (n_out != 20 || bus.count_o !== CW'(0) || bus.rd_valid_o !== 1'b0)
            $display("FAIL wrap_total got out=%0d count=%0d valid=%b want 20 0 0",
                     n_out, bus.count_o, bus.rd_valid_o);
        else n_pass++;
        $display("wrap: 20 entries streamed, %0d returned", n_out);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h00600093 + 32'(i), 64'h5100 + 64'(4 * i), 0, 0, 0);
            clock_edge();
        end
        drive(1, 32'hBADBAD13, 64'hDEAD0, 0, 1, 1);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b0)
            $display("FAIL flush_comb got valid=%b want 0", bus.rd_valid_o);
        else n_pass++;
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.count_o !== CW'(0) || bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1)
            $display("FAIL flush_after got count=%0d valid=%b ready=%b want 0 0 1",
                     bus.count_o, bus.rd_valid_o, bus.wr_ready_o);
        else n_pass++;
        drive(1, 32'h00700093, 64'h5000, 0, 0, 0);
        clock_edge();
        drive(1, 32'h00800093, 64'h5004, 0, 0, 0);
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_pc_o !== 64'h5000 || bus.count_o !== CW'(2))
            $display("FAIL flush_refill got valid=%b pc=%h count=%0d want 1 5000 2",
                     bus.rd_valid_o, bus.rd_pc_o, bus.count_o);
        else n_pass++;
        arst_i = 1'b1;
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b0 || bus.count_o !== CW'(0))
            $display("FAIL async_reset got valid=%b count=%0d want 0 0", bus.rd_valid_o, bus.count_o);
        else n_pass++;
        sb.delete();
        m_count = 0;
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        $display("flush: 3 held + push discarded; async reset mid-stream");
    endtask

    task automatic test_fault();
        drive(1, 32'h00000073, 64'h2000, 1, 0, 0);
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_fault_o !== 1'b1 || bus.rd_pc_o !== 64'h2000)
            $display("FAIL fault_head got fault=%b pc=%h want 1 2000", bus.rd_fault_o, bus.rd_pc_o);
        else n_pass++;
        drive(0, 32'h0, '0, 0, 1, 0);
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.rd_fault_o !== 1'b0 || bus.rd_valid_o !== 1'b0)
            $display("FAIL fault_cleared got fault=%b valid=%b want 0 0", bus.rd_fault_o, bus.rd_valid_o);
        else n_pass++;
        $display("fault: faulting fetch @0x2000 delivered");
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(1, 32'h00900093, 64'h6000, 0, 1, 0);
        #1;
        n_total++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_pc_o !== 64'h6000 || bus.rd_instr_o !== 32'h00900093)
            $display("FAIL bypass_same_cycle got valid=%b pc=%h instr=%h want 1 6000 00900093",
                     bus.rd_valid_o, bus.rd_pc_o, bus.rd_instr_o);
        else n_pass++;
        clock_edge();
        drive(0, 32'h0, '0, 0, 0, 0);
        #1;
        n_total++;
        if (bus.count_o !== CW'(0) || bus.rd_valid_o !== 1'b0)
            $display("FAIL bypass_not_stored got count=%0d valid=%b want 0 0", bus.count_o, bus.rd_valid_o);
        else n_pass++;
        $display("bypass: empty push consumed same cycle");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_fault();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
